// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg: shared types and helpers for the L2 port arbiter
package l2_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
    typedef enum logic {SRC_I, SRC_D} arb_src_t;
    localparam int ADDR_W = 32;
    localparam int OFS_W = 5;
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    endfunction
endpackage

// File: rtl/l2_arbiter_if.sv
// l2_arbiter_if: I-cache, D-cache, L2 and counter signals around the arbiter
interface l2_arbiter_if import l2_arbiter_pkg::*; #(
    parameter int S_LINE = 256,
    parameter int CNT_W = 16
);
    logic i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [S_LINE-1:0] i_rdata;
    logic i_resp;
    logic d_read;
    logic d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [S_LINE-1:0] d_wdata;
    logic [S_LINE-1:0] d_rdata;
    logic d_resp;
    logic l2_read;
    logic l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [S_LINE-1:0] l2_wdata;
    logic [S_LINE-1:0] l2_rdata;
    logic l2_resp;
    logic [CNT_W-1:0] i_grant_cnt;
    logic [CNT_W-1:0] d_grant_cnt;
    modport master (
        input i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
        output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata,
        output i_grant_cnt, d_grant_cnt
    );
    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
        input i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata,
        input i_grant_cnt, d_grant_cnt
    );
endinterface

// File: rtl/l2_arbiter_arb_grant_select.sv
// arb_grant_select: round-robin pick between I-cache and D-cache requests
module arb_grant_select import l2_arbiter_pkg::*; (
    input logic req_icache_i,
    input logic req_dcache_i,
    input arb_src_t last_grant_i,
    output logic grant_valid_o,
    output arb_src_t grant_src_o
);
    assign grant_valid_o = req_icache_i | req_dcache_i;
    assign grant_src_o = (req_dcache_i && (!req_icache_i || last_grant_i == SRC_I)) ? SRC_D : SRC_I;
endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the L2 line port between I-cache and D-cache miss ports
module l2_arbiter import l2_arbiter_pkg::*; #(
    parameter int S_LINE = 256,
    parameter int CNT_W = 16,
    parameter bit D_FIRST = 1'b1
) (
    input logic clk,
    input logic rst,
    l2_arbiter_if.master bus
);
    arb_state_t state_q;
    arb_src_t last_q;
    logic write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [S_LINE-1:0] wdata_q;
    logic [CNT_W-1:0] i_cnt_q;
    logic [CNT_W-1:0] d_cnt_q;
    logic grant_valid;
    arb_src_t grant_src;
    logic i_done;
    logic d_done;
    arb_grant_select u_sel (
        .req_icache_i (bus.i_read),
        .req_dcache_i (bus.d_read | bus.d_write),
        .last_grant_i (last_q),
        .grant_valid_o(grant_valid),
        .grant_src_o  (grant_src)
    );
    assign i_done = bus.l2_resp && state_q == SERVE_I;
    assign d_done = bus.l2_resp && state_q == SERVE_D;
    // Downstream comes only from captured registers so it is stable for the whole transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q <= D_FIRST ? SRC_I : SRC_D;
            write_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            i_cnt_q <= '0;
            d_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (grant_valid) begin
                state_q <= grant_src == SRC_D ? SERVE_D : SERVE_I;
                write_q <= grant_src == SRC_D && bus.d_write && !bus.d_read;
                addr_q <= line_align(grant_src == SRC_D ? bus.d_addr : bus.i_addr);
                wdata_q <= grant_src == SRC_D ? bus.d_wdata : '0;
            end
        end else if (bus.l2_resp) begin
            state_q <= IDLE;
            last_q <= state_q == SERVE_D ? SRC_D : SRC_I;
            if (i_done) i_cnt_q <= i_cnt_q + {{(CNT_W-1){1'b0}}, ~&i_cnt_q};
            if (d_done) d_cnt_q <= d_cnt_q + {{(CNT_W-1){1'b0}}, ~&d_cnt_q};
        end
    end
    assign bus.l2_read = state_q != IDLE && !write_q;
    assign bus.l2_write = state_q != IDLE && write_q;
    assign bus.l2_addr = addr_q;
    assign bus.l2_wdata = wdata_q;
    assign bus.i_resp = i_done;
    assign bus.d_resp = d_done;
    assign bus.i_rdata = i_done ? bus.l2_rdata : '0;
    assign bus.d_rdata = d_done ? bus.l2_rdata : '0;
    assign bus.i_grant_cnt = i_cnt_q;
    assign bus.d_grant_cnt = d_cnt_q;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: randomized self-checking bench with a transaction-level arbiter model
module tb_l2_arbiter;
    localparam int S_LINE = 256;
    localparam int CNT_W = 4;
    localparam int CMAX = 15;
    logic clk;
    logic rst;
    int checks;
    int errors;
    bit last_d;
    int cnt_i;
    int cnt_d;
    l2_arbiter_if #(.S_LINE(S_LINE), .CNT_W(CNT_W)) bus ();
    l2_arbiter #(.S_LINE(S_LINE), .CNT_W(CNT_W), .D_FIRST(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [S_LINE-1:0] rnd_line();
        logic [S_LINE-1:0] r;
        for (int k = 0; k < S_LINE / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic bit pick_d(input bit ri, input bit rd);
        return rd && !(ri && last_d);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        last_d = 1'b0;
        cnt_i = 0;
        cnt_d = 0;
    endtask

    task automatic serve(input bit src_d, input int lat, input bit wiggle);
        logic [31:0] ea;
        logic ew;
        logic [S_LINE-1:0] ed;
        logic [S_LINE-1:0] rd;
        int waited;
        ea = src_d ? bus.d_addr : bus.i_addr;
        ea[4:0] = 5'd0;
        ew = src_d && bus.d_write && !bus.d_read;
        ed = bus.d_wdata;
        waited = 0;
        step();
        waited++;
        while (!(bus.l2_read || bus.l2_write) && waited < 6) begin
            step();
            waited++;
        end
        checks++;
        if (waited != 1) begin
            errors++;
            $display("FAIL latency: request visible after %0d cycles, required 1", waited);
        end
        checks++;
        if ({bus.l2_read, bus.l2_write} !== {!ew, ew}) begin
            errors++;
            $display("FAIL op: rd/wr=%b%b required %b%b", bus.l2_read, bus.l2_write, !ew, ew);
        end
        checks++;
        if (bus.l2_addr !== ea) begin
            errors++;
            $display("FAIL addr: l2_addr=%h required %h", bus.l2_addr, ea);
        end
        if (ew) begin
            checks++;
            if (bus.l2_wdata !== ed) begin
                errors++;
                $display("FAIL wdata: l2_wdata=%h required %h", bus.l2_wdata, ed);
            end
        end
        for (int k = 1; k < lat; k++) begin
            step();
            if (wiggle) begin
                bus.d_addr = $urandom;
                bus.d_wdata = rnd_line();
                #1;
            end
            checks++;
            if ({bus.l2_read, bus.l2_write, bus.l2_addr, bus.i_resp, bus.d_resp} !== {!ew, ew, ea, 2'b00}) begin
                errors++;
                $display("FAIL hold: rd/wr=%b%b addr=%h resp=%b%b required %b%b %h 00",
                         bus.l2_read, bus.l2_write, bus.l2_addr, bus.i_resp, bus.d_resp, !ew, ew, ea);
            end
        end
        step();
        rd = rnd_line();
        bus.l2_rdata = rd;
        bus.l2_resp = 1'b1;
        #1;
        checks++;
        if ({bus.i_resp, bus.d_resp} !== {!src_d, src_d}) begin
            errors++;
            $display("FAIL route: i_resp/d_resp=%b%b required %b%b", bus.i_resp, bus.d_resp, !src_d, src_d);
        end
        checks++;
        if (bus.i_rdata !== (src_d ? '0 : rd) || bus.d_rdata !== (src_d ? rd : '0)) begin
            errors++;
            $display("FAIL rdata: i_rdata=%h d_rdata=%h l2_rdata=%h served_d=%0d",
                     bus.i_rdata, bus.d_rdata, rd, src_d);
        end
        step();
        bus.l2_resp = 1'b0;
        bus.l2_rdata = rnd_line();
        if (src_d) begin
            bus.d_read = 1'b0;
            bus.d_write = 1'b0;
            cnt_d = cnt_d == CMAX ? CMAX : cnt_d + 1;
        end else begin
            bus.i_read = 1'b0;
            cnt_i = cnt_i == CMAX ? CMAX : cnt_i + 1;
        end
        last_d = src_d;
        #1;
        checks++;
        if (bus.i_grant_cnt !== CNT_W'(cnt_i) || bus.d_grant_cnt !== CNT_W'(cnt_d)) begin
            errors++;
            $display("FAIL count: i=%0d d=%0d required i=%0d d=%0d", bus.i_grant_cnt, bus.d_grant_cnt, cnt_i, cnt_d);
        end
        checks++;
        if ({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp, |bus.i_rdata, |bus.d_rdata} !== 6'd0) begin
            errors++;
            $display("FAIL idle_gap: rd/wr=%b%b resp=%b%b rdata_nz=%b%b required all 0",
                     bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp, |bus.i_rdata, |bus.d_rdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp} !== 4'd0 || bus.l2_addr !== 32'd0 ||
            bus.l2_wdata !== '0 || bus.i_rdata !== '0 || bus.d_rdata !== '0 ||
            bus.i_grant_cnt !== '0 || bus.d_grant_cnt !== '0) begin
            errors++;
            $display("FAIL reset: rd=%b wr=%b addr=%h icnt=%0d dcnt=%0d required all 0",
                     bus.l2_read, bus.l2_write, bus.l2_addr, bus.i_grant_cnt, bus.d_grant_cnt);
        end
    endtask

    task automatic test_basic_read();
        bus.i_addr = 32'h0000_1234;
        bus.i_read = 1'b1;
        #1;
        checks++;
        if (bus.l2_read !== 1'b0) begin
            errors++;
            $display("FAIL cycle0: l2_read=%b required 0", bus.l2_read);
        end
        serve(1'b0, 3, 1'b0);
        checks++;
        if (bus.i_grant_cnt !== 4'd1) begin
            errors++;
            $display("FAIL basic_cnt: i_grant_cnt=%0d required 1", bus.i_grant_cnt);
        end
    endtask

    task automatic test_write();
        bus.d_addr = 32'h8000_0040;
        bus.d_wdata = {32{8'hA5}};
        bus.d_write = 1'b1;
        serve(pick_d(1'b0, 1'b1), 2, 1'b0);
    endtask

    task automatic test_read_precedence();
        bus.d_addr = $urandom;
        bus.d_wdata = rnd_line();
        bus.d_read = 1'b1;
        bus.d_write = 1'b1;
        serve(1'b1, 2, 1'b0);
    endtask

    task automatic test_contention();
        test_reset();
        bus.i_addr = $urandom;
        bus.d_addr = $urandom;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        for (int r = 0; r < 4; r++) begin
            serve(r % 2 == 0, $urandom_range(1, 4), 1'b0);
            if (r % 2 == 0) bus.d_read = 1'b1;
            else bus.i_read = 1'b1;
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.i_addr = 32'h0000_4440;
        bus.i_read = 1'b1;
        step();
        step();
        checks++;
        if (bus.l2_read !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: l2_read=%b required 1", bus.l2_read);
        end
        rst = 1'b1;
        step();
        bus.i_read = 1'b0;
        bus.l2_resp = 1'b1;
        #1;
        checks++;
        if ({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp} !== 4'd0 ||
            bus.i_grant_cnt !== '0 || bus.d_grant_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid: rd=%b resp=%b%b icnt=%0d dcnt=%0d required 0",
                     bus.l2_read, bus.i_resp, bus.d_resp, bus.i_grant_cnt, bus.d_grant_cnt);
        end
        rst = 1'b0;
        bus.l2_resp = 1'b0;
        model_reset();
        step();
    endtask

    task automatic test_saturation();
        test_reset();
        for (int n = 0; n < 17; n++) begin
            bus.i_addr = $urandom;
            bus.i_read = 1'b1;
            serve(1'b0, $urandom_range(1, 3), 1'b0);
        end
        checks++;
        if (bus.i_grant_cnt !== 4'd15) begin
            errors++;
            $display("FAIL saturate: i_grant_cnt=%0d required 15", bus.i_grant_cnt);
        end
    endtask

    task automatic test_addr_hold();
        bus.d_addr = 32'h1234_5678;
        bus.d_read = 1'b1;
        serve(1'b1, 4, 1'b1);
    endtask

    task automatic test_idle_resp();
        bus.l2_rdata = rnd_line();
        bus.l2_resp = 1'b1;
        #1;
        checks++;
        if ({bus.i_resp, bus.d_resp} !== 2'b00 || bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
            errors++;
            $display("FAIL idle_resp: resp=%b%b required 00", bus.i_resp, bus.d_resp);
        end
        step();
        bus.l2_resp = 1'b0;
        #1;
        checks++;
        if (bus.i_grant_cnt !== CNT_W'(cnt_i) || bus.d_grant_cnt !== CNT_W'(cnt_d) || bus.l2_read || bus.l2_write) begin
            errors++;
            $display("FAIL idle_cnt: i=%0d d=%0d required i=%0d d=%0d", bus.i_grant_cnt, bus.d_grant_cnt, cnt_i, cnt_d);
        end
    endtask

    task automatic test_random();
        bit ri;
        bit rdv;
        bit s;
        int op;
        for (int it = 0; it < 40; it++) begin
            ri = $urandom_range(0, 1);
            op = $urandom_range(0, 3);
            rdv = op != 0;
            bus.i_addr = $urandom;
            bus.d_addr = $urandom;
            bus.d_wdata = rnd_line();
            bus.i_read = ri;
            bus.d_read = op[0];
            bus.d_write = op[1];
            if (!ri && !rdv) test_idle_resp();
            while (ri || rdv) begin
                s = pick_d(ri, rdv);
                serve(s, $urandom_range(1, 5), s && $urandom_range(0, 1));
                if (s) rdv = 1'b0;
                else ri = 1'b0;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.i_read = 1'b0;
        bus.i_addr = '0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.l2_rdata = '0;
        bus.l2_resp = 1'b0;
        model_reset();
        test_reset();
        test_basic_read();
        test_write();
        test_read_precedence();
        test_idle_resp();
        test_contention();
        test_reset_mid();
        test_addr_hold();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        #2;
        if (bus.l2_read && bus.l2_write) begin
            errors++;
            $display("FAIL exclusive: l2_read and l2_write both 1");
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
